// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for CPU mem_read/mem_write requests.
//
// Holds a DEPTH x DATA_W RAM. A CPU access is sampled in IDLE, waits
// WAIT_CYCLES extra cycles, then completes with a one-cycle ready pulse
// (err valid alongside it). A side-band loader port can write the RAM while
// the responder is idle; it has priority over a CPU request in the same cycle.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   mem_read   read request (level)
//   mem_write  write request (level)
//   addr_bus   request address
//   wdata      write data
//   rdata      read data, valid with ready and held afterwards
//   ready      one-cycle completion pulse
//   err        error flag (both requests high, or address out of range)
//   busy       high whenever the responder is not idle
//   load_we    loader write strobe
//   load_addr  loader address
//   load_data  loader data
//   load_ack   one-cycle pulse after a loader write is accepted
module mem_responder #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr_bus,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              err,
  output logic              busy,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ack
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic              op_write_reg, op_write_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic [DATA_W-1:0] rdata_reg;
  logic              ready_reg, ready_next;
  logic              err_reg, err_next;
  logic              busy_reg, busy_next;
  logic              load_ack_reg, load_ack_next;

  // Single RAM write port shared by the loader and CPU writes; the two can
  // never fire in the same cycle because the loader is only honoured in IDLE
  // and a CPU access from IDLE is only taken when load_we is low.
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // Read side: rd_en loads rdata from the RAM, rd_zero clears it for an
  // out-of-range read.
  logic              rd_en;
  logic              rd_zero;
  logic [ADDR_W-1:0] rd_addr;

  // The access being performed on this edge (either straight from the bus
  // when there are no wait states, or from the latched request).
  logic              acc_go;
  logic              acc_write;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;

  logic [DATA_W-1:0] mem [DEPTH];

  // Widened compare so DEPTH == 2**ADDR_W does not overflow.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return (33'(a) < 33'(DEPTH));
  endfunction

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    op_write_next = op_write_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    ready_next    = 1'b0;
    err_next      = 1'b0;
    load_ack_next = 1'b0;
    mem_we        = 1'b0;
    mem_waddr     = load_addr;
    mem_wdata     = load_data;
    rd_en         = 1'b0;
    rd_zero       = 1'b0;
    rd_addr       = addr_reg;
    acc_go        = 1'b0;
    acc_write     = op_write_reg;
    acc_addr      = addr_reg;
    acc_wdata     = wdata_reg;

    case (state_reg)
      IDLE: begin
        if (load_we) begin
          // Out-of-range loader writes are dropped but still acknowledged.
          mem_we        = in_range(load_addr);
          load_ack_next = 1'b1;
        end else if (mem_read ^ mem_write) begin
          op_write_next = mem_write;
          addr_next     = addr_bus;
          wdata_next    = wdata;
          if (WAIT_CYCLES == 0) begin
            acc_go    = 1'b1;
            acc_write = mem_write;
            acc_addr  = addr_bus;
            acc_wdata = wdata;
          end else begin
            cnt_next   = 4'(WAIT_CYCLES - 1);
            state_next = WAIT;
          end
        end else if (mem_read && mem_write) begin
          // Conflicting request: complete immediately with an error.
          state_next = DONE;
          ready_next = 1'b1;
          err_next   = 1'b1;
        end
      end
      WAIT: begin
        if (cnt_reg == 4'd0) begin
          acc_go = 1'b1;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (acc_go) begin
      state_next = DONE;
      ready_next = 1'b1;
      if (in_range(acc_addr)) begin
        if (acc_write) begin
          mem_we    = 1'b1;
          mem_waddr = acc_addr;
          mem_wdata = acc_wdata;
        end else begin
          rd_en   = 1'b1;
          rd_addr = acc_addr;
        end
      end else begin
        err_next = 1'b1;
        rd_zero  = !acc_write;
      end
    end

    busy_next = (state_next != IDLE);
  end

  // RAM contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr[IDX_W-1:0]] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= 4'd0;
      op_write_reg <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      rdata_reg    <= '0;
      ready_reg    <= 1'b0;
      err_reg      <= 1'b0;
      busy_reg     <= 1'b0;
      load_ack_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      op_write_reg <= op_write_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      ready_reg    <= ready_next;
      err_reg      <= err_next;
      busy_reg     <= busy_next;
      load_ack_reg <= load_ack_next;
      if (rd_en) begin
        rdata_reg <= mem[rd_addr[IDX_W-1:0]];
      end else if (rd_zero) begin
        rdata_reg <= '0;
      end
    end
  end

  assign rdata    = rdata_reg;
  assign ready    = ready_reg;
  assign err      = err_reg;
  assign busy     = busy_reg;
  assign load_ack = load_ack_reg;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances with different WAIT_CYCLES/DEPTH,
// a transaction-level reference model, a per-cycle compare process and a few
// directed scenarios with literal expectations.
module tb_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [2:0]      mem_read_s  = '0;
  logic [2:0]      mem_write_s = '0;
  logic [2:0]      load_we_s   = '0;
  logic [2:0][7:0] addr_s      = '0;
  logic [2:0][7:0] wdata_s     = '0;
  logic [2:0][7:0] load_addr_s = '0;
  logic [2:0][7:0] load_data_s = '0;
  logic [2:0][7:0] rdata_s;
  logic [2:0]      ready_s, err_s, busy_s, load_ack_s;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_responder #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(0)) u_d0 (
    .clk(clk), .rst(rst), .mem_read(mem_read_s[0]), .mem_write(mem_write_s[0]),
    .addr_bus(addr_s[0]), .wdata(wdata_s[0]), .rdata(rdata_s[0]), .ready(ready_s[0]),
    .err(err_s[0]), .busy(busy_s[0]), .load_we(load_we_s[0]), .load_addr(load_addr_s[0]),
    .load_data(load_data_s[0]), .load_ack(load_ack_s[0]));

  mem_responder #(.DATA_W(8), .ADDR_W(8), .DEPTH(16), .WAIT_CYCLES(3)) u_d1 (
    .clk(clk), .rst(rst), .mem_read(mem_read_s[1]), .mem_write(mem_write_s[1]),
    .addr_bus(addr_s[1]), .wdata(wdata_s[1]), .rdata(rdata_s[1]), .ready(ready_s[1]),
    .err(err_s[1]), .busy(busy_s[1]), .load_we(load_we_s[1]), .load_addr(load_addr_s[1]),
    .load_data(load_data_s[1]), .load_ack(load_ack_s[1]));

  mem_responder #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(4)) u_d2 (
    .clk(clk), .rst(rst), .mem_read(mem_read_s[2]), .mem_write(mem_write_s[2]),
    .addr_bus(addr_s[2]), .wdata(wdata_s[2]), .rdata(rdata_s[2]), .ready(ready_s[2]),
    .err(err_s[2]), .busy(busy_s[2]), .load_we(load_we_s[2]), .load_addr(load_addr_s[2]),
    .load_data(load_data_s[2]), .load_ack(load_ack_s[2]));

  function automatic int wait_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 3 : 4);
  endfunction

  function automatic int depth_of(input int d);
    return (d == 1) ? 16 : 256;
  endfunction

  task automatic check(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails < 40)
        $display("[TB] FAIL %s dut%0d: got %0h, expected %0h at t=%0t", name, d, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model: each accepted request completes WAIT cycles after its
  // sampling edge; the responder can sample again two edges after that.
  // ---------------------------------------------------------------------
  int         edge_k;
  int         next_edge [3];
  int         done_edge [3];
  bit         p_wr      [3];
  logic [7:0] p_addr    [3];
  logic [7:0] p_wdata   [3];
  bit         e_ready   [3];
  bit         e_err     [3];
  bit         e_busy    [3];
  bit         e_ack     [3];
  logic [7:0] e_rdata   [3];
  bit         e_known   [3];
  logic [7:0] mmem      [3][256];
  bit         mval      [3][256];

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      next_edge[d] = 0;
      done_edge[d] = -1;
      e_ready[d]   = 1'b0;
      e_err[d]     = 1'b0;
      e_busy[d]    = 1'b0;
      e_ack[d]     = 1'b0;
      e_rdata[d]   = 8'h00;
      e_known[d]   = 1'b1;
    end
  endtask

  initial begin
    edge_k = 0;
    model_reset();
    for (int d = 0; d < 3; d++)
      for (int a = 0; a < 256; a++) mval[d][a] = 1'b0;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        model_reset();
      end else begin
        edge_k++;
        for (int d = 0; d < 3; d++) begin
          e_ready[d] = 1'b0;
          e_err[d]   = 1'b0;
          e_ack[d]   = 1'b0;
          if (edge_k >= next_edge[d]) begin
            if (load_we_s[d]) begin
              if (int'(load_addr_s[d]) < depth_of(d)) begin
                mmem[d][load_addr_s[d]] = load_data_s[d];
                mval[d][load_addr_s[d]] = 1'b1;
              end
              e_ack[d] = 1'b1;
            end else if (mem_read_s[d] != mem_write_s[d]) begin
              p_wr[d]      = mem_write_s[d];
              p_addr[d]    = addr_s[d];
              p_wdata[d]   = wdata_s[d];
              done_edge[d] = edge_k + wait_of(d);
              next_edge[d] = edge_k + wait_of(d) + 2;
            end else if (mem_read_s[d] && mem_write_s[d]) begin
              e_ready[d]   = 1'b1;
              e_err[d]     = 1'b1;
              next_edge[d] = edge_k + 2;
            end
          end
          if (done_edge[d] == edge_k) begin
            if (int'(p_addr[d]) < depth_of(d)) begin
              if (p_wr[d]) begin
                mmem[d][p_addr[d]] = p_wdata[d];
                mval[d][p_addr[d]] = 1'b1;
              end else begin
                e_rdata[d] = mmem[d][p_addr[d]];
                e_known[d] = mval[d][p_addr[d]];
              end
            end else begin
              e_err[d] = 1'b1;
              if (!p_wr[d]) begin
                e_rdata[d] = 8'h00;
                e_known[d] = 1'b1;
              end
            end
            e_ready[d]   = 1'b1;
            done_edge[d] = -1;
          end
          e_busy[d] = (edge_k + 1 < next_edge[d]);
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        check("ready", d, 32'(ready_s[d]), 32'(e_ready[d]));
        check("err", d, 32'(err_s[d]), 32'(e_err[d]));
        check("busy", d, 32'(busy_s[d]), 32'(e_busy[d]));
        check("load_ack", d, 32'(load_ack_s[d]), 32'(e_ack[d]));
        if (e_known[d]) check("rdata", d, 32'(rdata_s[d]), 32'(e_rdata[d]));
      end
    end
  end

  // ---------------------------------------------------------------------
  // Drivers
  // ---------------------------------------------------------------------
  task automatic access(input int d, input bit rd, input bit wr, input logic [7:0] a,
                        input logic [7:0] wd, input bit scramble,
                        output logic [7:0] rv, output bit ev, output int lat);
    bit found;
    @(negedge clk);
    mem_read_s[d]  = rd;
    mem_write_s[d] = wr;
    addr_s[d]      = a;
    wdata_s[d]     = wd;
    lat   = 0;
    rv    = 8'h00;
    ev    = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      lat++;
      if (ready_s[d]) begin
        found = 1'b1;
        rv    = rdata_s[d];
        ev    = err_s[d];
      end else if (scramble) begin
        addr_s[d]  = 8'($urandom);
        wdata_s[d] = 8'($urandom);
      end
    end
    mem_read_s[d]  = 1'b0;
    mem_write_s[d] = 1'b0;
    check("ready_seen", d, 32'(found), 32'd1);
    $display("[TB] dut%0d %s addr=%02h wdata=%02h -> rdata=%02h err=%0b lat=%0d",
             d, (rd && wr) ? "both " : (wr ? "write" : "read "), a, wd, rv, ev, lat);
  endtask

  task automatic load(input int d, input logic [7:0] a, input logic [7:0] v, input bit verbose);
    bit found;
    @(negedge clk);
    load_we_s[d]   = 1'b1;
    load_addr_s[d] = a;
    load_data_s[d] = v;
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (load_ack_s[d]) found = 1'b1;
    end
    load_we_s[d] = 1'b0;
    check("load_ack_seen", d, 32'(found), 32'd1);
    if (verbose) $display("[TB] dut%0d load  addr=%02h data=%02h", d, a, v);
  endtask

  task automatic rand_run(input int d, input int n);
    logic [7:0] rv, a;
    bit         ev;
    int         lat, sel;
    for (int i = 0; i < n; i++) begin
      sel = $urandom_range(0, 99);
      a   = (d == 1 && $urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
      if (sel < 25)      load(d, a, 8'($urandom), 1'b1);
      else if (sel < 30) access(d, 1'b1, 1'b1, a, 8'($urandom), 1'b1, rv, ev, lat);
      else if (sel < 65) access(d, 1'b1, 1'b0, a, 8'($urandom), 1'b1, rv, ev, lat);
      else               access(d, 1'b0, 1'b1, a, 8'($urandom), 1'b1, rv, ev, lat);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  // ---------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------
  initial begin
    logic [7:0] rv;
    bit         ev;
    int         lat;

    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check("rst_busy", d, 32'(busy_s[d]), 32'd0);
      check("rst_ready", d, 32'(ready_s[d]), 32'd0);
      check("rst_rdata", d, 32'(rdata_s[d]), 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;

    // Preload every address of every instance through the loader.
    fork
      for (int a = 0; a < 256; a++) load(0, 8'(a), 8'(a * 7 + 3), 1'b0);
      for (int a = 0; a < 256; a++) load(1, 8'(a), 8'(a * 5 + 1), 1'b0);
      for (int a = 0; a < 256; a++) load(2, 8'(a), 8'(a * 3 + 9), 1'b0);
    join

    // No wait states: write then read back.
    access(0, 1'b0, 1'b1, 8'h10, 8'hA5, 1'b0, rv, ev, lat);
    check("t1_wr_err", 0, 32'(ev), 32'd0);
    check("t1_wr_lat", 0, 32'(lat), 32'd1);
    access(0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, rv, ev, lat);
    check("t1_rd_data", 0, 32'(rv), 32'hA5);
    check("t1_rd_err", 0, 32'(ev), 32'd0);
    check("t1_rd_lat", 0, 32'(lat), 32'd1);

    // Three wait states.
    access(1, 1'b0, 1'b1, 8'h03, 8'h5A, 1'b0, rv, ev, lat);
    access(1, 1'b1, 1'b0, 8'h03, 8'h00, 1'b0, rv, ev, lat);
    check("t2_rd_data", 1, 32'(rv), 32'h5A);
    check("t2_rd_lat", 1, 32'(lat), 32'd4);

    // Both requests high: error, RAM untouched.
    access(0, 1'b1, 1'b1, 8'h10, 8'h33, 1'b0, rv, ev, lat);
    check("t3_err", 0, 32'(ev), 32'd1);
    check("t3_lat", 0, 32'(lat), 32'd1);
    check("t3_rdata_held", 0, 32'(rv), 32'hA5);
    access(0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, rv, ev, lat);
    check("t3_readback", 0, 32'(rv), 32'hA5);

    // Loader wins over a same-cycle read; the read follows one edge later.
    @(negedge clk);
    load_we_s[0] = 1'b1; load_addr_s[0] = 8'h20; load_data_s[0] = 8'h3C;
    mem_read_s[0] = 1'b1; addr_s[0] = 8'h20;
    @(negedge clk);
    check("t4_ack", 0, 32'(load_ack_s[0]), 32'd1);
    check("t4_no_ready", 0, 32'(ready_s[0]), 32'd0);
    load_we_s[0] = 1'b0;
    @(negedge clk);
    check("t4_ready", 0, 32'(ready_s[0]), 32'd1);
    check("t4_rdata", 0, 32'(rdata_s[0]), 32'h3C);
    mem_read_s[0] = 1'b0;
    $display("[TB] dut0 load+read addr=20 -> rdata=%02h", rdata_s[0]);

    // Reset in the middle of a write with four wait states.
    load(2, 8'h05, 8'h11, 1'b1);
    @(negedge clk);
    mem_write_s[2] = 1'b1; addr_s[2] = 8'h05; wdata_s[2] = 8'h77;
    @(posedge clk);
    @(negedge clk);
    check("t5_busy_before", 2, 32'(busy_s[2]), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("t5_busy_rst", 2, 32'(busy_s[2]), 32'd0);
    check("t5_ready_rst", 2, 32'(ready_s[2]), 32'd0);
    check("t5_rdata_rst", 2, 32'(rdata_s[2]), 32'd0);
    @(negedge clk);
    mem_write_s[2] = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    $display("[TB] dut2 reset during write addr=05");
    access(2, 1'b1, 1'b0, 8'h05, 8'h00, 1'b0, rv, ev, lat);
    check("t5_readback", 2, 32'(rv), 32'h11);
    check("t5_lat", 2, 32'(lat), 32'd5);

    // Out-of-range addresses with DEPTH=16.
    access(1, 1'b0, 1'b1, 8'h20, 8'h99, 1'b0, rv, ev, lat);
    check("t6_wr_err", 1, 32'(ev), 32'd1);
    access(1, 1'b1, 1'b0, 8'h20, 8'h00, 1'b0, rv, ev, lat);
    check("t6_rd_err", 1, 32'(ev), 32'd1);
    check("t6_rd_zero", 1, 32'(rv), 32'd0);
    access(1, 1'b0, 1'b1, 8'h0F, 8'h42, 1'b0, rv, ev, lat);
    check("t6_edge_wr_err", 1, 32'(ev), 32'd0);
    access(1, 1'b1, 1'b0, 8'h0F, 8'h00, 1'b0, rv, ev, lat);
    check("t6_edge_rd", 1, 32'(rv), 32'h42);
    check("t6_edge_rd_err", 1, 32'(ev), 32'd0);

    // Randomised traffic on all three instances at once.
    fork
      rand_run(0, 120);
      rand_run(1, 120);
      rand_run(2, 120);
    join

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
